// File: rtl/bpu_pkg.sv
// Shared types for the branch target buffer: direction counter states,
// per-entry status bits and the performance-counter ceiling.
package bpu_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } ctr_t;

   // Tag and target widths depend on the BTB parameters, so they live beside
   // this struct in the BTB itself rather than inside it.
   typedef struct packed {
      logic valid;
      logic is_jump;
      ctr_t ctr;
   } btb_entry_t;

   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/bpu_sat_ctr.sv
// 2-bit saturating direction counter next-state function.
module bpu_sat_ctr
   import bpu_pkg::*;
(
   input  ctr_t cur,
   input  logic taken,
   output ctr_t nxt
);

   always_comb begin
      nxt = cur;
      unique case (cur)
         SNT: nxt = taken ? WNT : SNT;
         WNT: nxt = taken ? WT  : SNT;
         WT:  nxt = taken ? ST  : WNT;
         ST:  nxt = taken ? ST  : WT;
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters, mispredict
// detection and performance counters. Define BPU_GSHARE_EN to hash the index with global history.
module bpu_btb
   import bpu_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned ENTRIES  = 16,
   parameter int unsigned GHR_BITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] PCF,
   output logic [WIDTH-1:0] PCBPU,
   output logic             PCBPUSrc,
   input  logic             ResolveE,
   input  logic             BranchE,
   input  logic             JumpE,
   input  logic [WIDTH-1:0] PCE,
   input  logic [WIDTH-1:0] TargetE,
   input  logic             ActualTakenE,
   input  logic             PredTakenE,
   input  logic [WIDTH-1:0] PredTargetE,
   output logic             flushBranch,
   output logic [WIDTH-1:0] PCCorrect,
   output logic [31:0]      BranchCount,
   output logic [31:0]      MispredCount
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = WIDTH - IDX_W - 2;

   btb_entry_t       meta_q [ENTRIES];
   logic [TAG_W-1:0] tag_q  [ENTRIES];
   logic [WIDTH-1:0] tgt_q  [ENTRIES];

   logic [IDX_W-1:0] idx_f, idx_e;
   logic [TAG_W-1:0] tag_f, tag_e;
   logic             hit_f, hit_e, upd, mispred;
   ctr_t             ctr_nxt;
   logic             pc_align_unused;

   assign pc_align_unused = ^{PCF[1:0], PCE[1:0]};

`ifdef BPU_GSHARE_EN
   logic [GHR_BITS-1:0] ghr_q;

   assign idx_f = PCF[IDX_W+1:2] ^ IDX_W'(ghr_q);
   assign idx_e = PCE[IDX_W+1:2] ^ IDX_W'(ghr_q);

   // History tracks resolved conditional branches only; jumps never shift it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ghr_q <= '0;
      end else if (upd && BranchE) begin
         ghr_q <= GHR_BITS'({ghr_q, ActualTakenE});
      end
   end
`else
   localparam int unsigned ghr_bits_unused = GHR_BITS;

   assign idx_f = PCF[IDX_W+1:2];
   assign idx_e = PCE[IDX_W+1:2];
`endif

   assign tag_f = PCF[WIDTH-1:IDX_W+2];
   assign tag_e = PCE[WIDTH-1:IDX_W+2];

   assign hit_f = meta_q[idx_f].valid && (tag_q[idx_f] == tag_f);
   assign hit_e = meta_q[idx_e].valid && (tag_q[idx_e] == tag_e);
   assign upd   = ResolveE && (BranchE || JumpE);

   assign PCBPUSrc = !rst && hit_f && (meta_q[idx_f].is_jump || (meta_q[idx_f].ctr inside {WT, ST}));
   assign PCBPU    = (!rst && hit_f) ? tgt_q[idx_f] : '0;

   assign mispred = ResolveE && ((PredTakenE != ActualTakenE) ||
                                 (PredTakenE && ActualTakenE && (PredTargetE != TargetE)));
   assign flushBranch = !rst && mispred;
   assign PCCorrect   = ActualTakenE ? TargetE : PCE + WIDTH'(4);

   bpu_sat_ctr u_sat_ctr (
      .cur   (meta_q[idx_e].ctr),
      .taken (ActualTakenE),
      .nxt   (ctr_nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            meta_q[i] <= '{valid: 1'b0, is_jump: 1'b0, ctr: SNT};
         end
      end else if (upd) begin
         if (hit_e) begin
            meta_q[idx_e].ctr <= ctr_nxt;
         end else if (ActualTakenE) begin
            meta_q[idx_e] <= '{valid: 1'b1, is_jump: JumpE, ctr: WT};
         end
      end
   end

   // Tag/target need no reset: they are only observable through a valid bit.
   always_ff @(posedge clk) begin
      if (upd && ActualTakenE) begin
         tag_q[idx_e] <= tag_e;
         tgt_q[idx_e] <= TargetE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         BranchCount  <= '0;
         MispredCount <= '0;
      end else begin
         if (upd && (BranchCount != CNT_MAX)) begin
            BranchCount <= BranchCount + 32'd1;
         end
         if (mispred && (MispredCount != CNT_MAX)) begin
            MispredCount <= MispredCount + 32'd1;
         end
      end
   end

endmodule

// File: doc/bpu_btb.md
BPU_BTB -- requirements
Module: bpu_btb

Interface
REQ-001 Parameter WIDTH, default 32: address/data width.
REQ-002 Parameter ENTRIES, default 16: BTB entries; power of two, 4..256.
REQ-003 Parameter GHR_BITS, default 4: global history length, used only with BPU_GSHARE_EN; GHR_BITS <= log2(ENTRIES).
REQ-004 Ports: clk in 1 (sole clock, rising edge); rst in 1 (asynchronous, active-high).
REQ-005 PCF in WIDTH: fetch PC for lookup.
REQ-006 PCBPU out WIDTH: predicted target; PCBPUSrc out 1: take predicted target.
REQ-007 ResolveE in 1: control-flow instruction in Execute, pipeline not stalled.
REQ-008 BranchE, JumpE in 1 each: Execute instruction is a conditional branch or a jump (JAL/JALR).
REQ-009 PCE, TargetE in WIDTH: Execute PC and computed target; ActualTakenE in 1: resolved direction.
REQ-010 PredTakenE in 1, PredTargetE in WIDTH: prediction made at fetch, carried down the pipeline.
REQ-011 flushBranch out 1: mispredict; PCCorrect out WIDTH: redirect PC.
REQ-012 BranchCount, MispredCount out 32 each: performance counters.

Function
REQ-013 Index = PCF[log2(ENTRIES)+1:2]; tag = PCF[WIDTH-1:log2(ENTRIES)+2]; entry = {valid, tag, target, is_jump, ctr[1:0]}.
REQ-014 Lookup is combinational: hit = valid && tag match; PCBPUSrc = hit && (is_jump || ctr[1]); PCBPU = target on hit, else 0.
REQ-015 ctr is a 4-state FSM SNT(00)->WNT(01)->WT(10)->ST(11); taken increments, not-taken decrements; saturates at ST and SNT.
REQ-016 Update occurs at the rising edge where ResolveE=1 and (BranchE||JumpE); visible to lookups from the next cycle (1-cycle latency).
REQ-017 Resolved taken, miss: allocate (overwrite) entry, set valid, tag, target=TargetE, is_jump=JumpE, ctr=WT.
REQ-018 Resolved taken, hit: target=TargetE, ctr increments.
REQ-019 Resolved not-taken, hit: ctr decrements; not-taken miss: no allocation.
REQ-020 Same-cycle lookup and update of one index: lookup returns pre-update contents; no bypass.
REQ-021 flushBranch = ResolveE && (PredTakenE != ActualTakenE || (PredTakenE && ActualTakenE && PredTargetE != TargetE)); combinational, same cycle.
REQ-022 PCCorrect = ActualTakenE ? TargetE : PCE + 4, with WIDTH-bit wrap-around.
REQ-023 BranchCount increments on each update; MispredCount increments when flushBranch=1; both saturate at 0xFFFFFFFF.

Reset
REQ-024 rst asserted clears every valid bit, every ctr to SNT, GHR, and both counters immediately, independent of clk.
REQ-025 While rst=1: PCBPUSrc=0, PCBPU=0, flushBranch=0; no update occurs.
REQ-026 rst asserted mid-update discards the update; the first update after deassertion sees an empty BTB.

Configuration
REQ-027 Macro BPU_GSHARE_EN defined: index = PC index bits XOR zero-extended GHR; GHR shifts left, inserting ActualTakenE on each update with BranchE=1 (not on jumps); GHR non-speculative.
REQ-028 Macro BPU_GSHARE_EN undefined: no GHR storage; index from PC only; GHR_BITS ignored.

Structure
REQ-029 Package bpu_pkg holds the ctr_t enum (SNT/WNT/WT/ST), the BTB entry struct and the counter saturation constant.
REQ-030 Sub-module bpu_sat_ctr implements the 2-bit saturating next-state function; bpu_btb instantiates it once, in the update path.

Verification
REQ-031 Reset, PCF=0x40 -> PCBPUSrc=0, PCBPU=0, both counters 0.
REQ-032 Resolve taken branch PCE=0x40, TargetE=0x80, PredTakenE=0 -> flushBranch=1, PCCorrect=0x80; next cycle PCF=0x40 -> PCBPUSrc=1, PCBPU=0x80.
REQ-033 Same branch resolved not-taken twice -> ctr WT->WNT->SNT; PCF=0x40 then PCBPUSrc=0; third not-taken holds SNT.
REQ-034 JAL at 0x10 to 0x200, then same JAL re-resolved with TargetE=0x300 and PredTargetE=0x200 -> flushBranch=1, entry target 0x300, PCBPUSrc=1 regardless of ctr.
REQ-035 Aliasing, ENTRIES=16: taken at 0x40 then taken at 0x80 (same index) -> 0x80 replaces 0x40; PCF=0x40 misses.
REQ-036 rst pulsed between clk edges with ResolveE=1 -> no entry written, MispredCount stays 0; with BPU_GSHARE_EN, GHR reads 0.
